// File: rtl/sram_arb_pkg.sv
// Shared encodings for the sram-like port arbiter: FSM states and grant owner ids.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/sram_port_arbiter_if.sv
// One sram-like port: request fields from the master, handshake and read data from the slave.
interface sram_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic                  req;
  logic                  wr;
  logic [DATA_W/8-1:0]   wstrb;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     wdata;
  logic                  addr_ok;
  logic                  data_ok;
  logic [DATA_W-1:0]     rdata;

  modport master (
    output req, wr, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_arb_pick.sv
// Combinational winner select between fetch and load/store requesters.
// ARB_ROUND_ROBIN_EN: ties go to the requester that did not win last time.
module sram_arb_pick
  import sram_arb_pkg::*;
(
  input  logic       inst_req,
  input  logic       data_req,
`ifdef ARB_ROUND_ROBIN_EN
  input  arb_owner_e last_owner,
`endif
  output logic       grant,
  output arb_owner_e winner
);

  always_comb begin
    grant  = inst_req | data_req;
    winner = OWN_DATA;
    if (inst_req && !data_req) begin
      winner = OWN_INST;
    end
`ifdef ARB_ROUND_ROBIN_EN
    else if (inst_req && data_req && (last_owner == OWN_DATA)) begin
      winner = OWN_INST;
    end
`endif
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one downstream sram-like port between the fetch and load/store requesters,
// one transaction in flight. ARB_ROUND_ROBIN_EN selects round-robin tie breaking.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  sram_port_arbiter_if.slave   inst,
  sram_port_arbiter_if.slave   data,
  sram_port_arbiter_if.master  mem
);

  arb_state_e           state_q, state_d;
  arb_owner_e           owner_q, owner_d;
  logic                 wr_q, wr_d;
  logic [DATA_W/8-1:0]  wstrb_q, wstrb_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic [DATA_W-1:0]    inst_rdata_q, inst_rdata_d;
  logic [DATA_W-1:0]    data_rdata_q, data_rdata_d;
  logic                 inst_data_ok_q, inst_data_ok_d;
  logic                 data_data_ok_q, data_data_ok_d;
  logic                 inst_addr_ok;
  logic                 data_addr_ok;
  logic                 pick_grant;
  arb_owner_e           pick_winner;

`ifdef ARB_ROUND_ROBIN_EN
  arb_owner_e           last_owner_q, last_owner_d;

  sram_arb_pick u_pick (
    .inst_req   (inst.req),
    .data_req   (data.req),
    .last_owner (last_owner_q),
    .grant      (pick_grant),
    .winner     (pick_winner)
  );
`else
  sram_arb_pick u_pick (
    .inst_req   (inst.req),
    .data_req   (data.req),
    .grant      (pick_grant),
    .winner     (pick_winner)
  );
`endif

  always_comb begin
    state_d        = state_q;
    owner_d        = owner_q;
    wr_d           = wr_q;
    wstrb_d        = wstrb_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    inst_rdata_d   = inst_rdata_q;
    data_rdata_d   = data_rdata_q;
    inst_data_ok_d = 1'b0;
    data_data_ok_d = 1'b0;
    inst_addr_ok   = 1'b0;
    data_addr_ok   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
    last_owner_d   = last_owner_q;
`endif

    unique case (state_q)
      IDLE: begin
        // No acceptance while rst is high: the latches would be cleared, not loaded.
        if (pick_grant && !rst) begin
          owner_d = pick_winner;
          state_d = ADDR;
`ifdef ARB_ROUND_ROBIN_EN
          last_owner_d = pick_winner;
`endif
          if (pick_winner == OWN_DATA) begin
            data_addr_ok = 1'b1;
            wr_d         = data.wr;
            wstrb_d      = data.wstrb;
            addr_d       = data.addr;
            wdata_d      = data.wdata;
          end else begin
            inst_addr_ok = 1'b1;
            wr_d         = 1'b0;
            wstrb_d      = '0;
            addr_d       = inst.addr;
            wdata_d      = '0;
          end
        end
      end
      ADDR: begin
        if (mem.addr_ok) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (mem.data_ok) begin
          state_d = IDLE;
          if (owner_q == OWN_INST) begin
            inst_rdata_d   = mem.rdata;
            inst_data_ok_d = 1'b1;
          end else begin
            data_data_ok_d = 1'b1;
            if (!wr_q) begin
              data_rdata_d = mem.rdata;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      owner_q        <= OWN_INST;
      wr_q           <= 1'b0;
      wstrb_q        <= '0;
      addr_q         <= '0;
      wdata_q        <= '0;
      inst_rdata_q   <= '0;
      data_rdata_q   <= '0;
      inst_data_ok_q <= 1'b0;
      data_data_ok_q <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q   <= OWN_INST;
`endif
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      wr_q           <= wr_d;
      wstrb_q        <= wstrb_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      inst_rdata_q   <= inst_rdata_d;
      data_rdata_q   <= data_rdata_d;
      inst_data_ok_q <= inst_data_ok_d;
      data_data_ok_q <= data_data_ok_d;
`ifdef ARB_ROUND_ROBIN_EN
      last_owner_q   <= last_owner_d;
`endif
    end
  end

  assign inst.addr_ok = inst_addr_ok;
  assign inst.data_ok = inst_data_ok_q;
  assign inst.rdata   = inst_rdata_q;
  assign data.addr_ok = data_addr_ok;
  assign data.data_ok = data_data_ok_q;
  assign data.rdata   = data_rdata_q;

  assign mem.req   = (state_q == ADDR);
  assign mem.wr    = wr_q;
  assign mem.wstrb = wstrb_q;
  assign mem.addr  = addr_q;
  assign mem.wdata = wdata_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a transaction-level reference model
// checked every cycle; honours ARB_ROUND_ROBIN_EN for the expected tie order.
module tb_sram_port_arbiter;
  import sram_arb_pkg::*;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) inst_if ();
  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) data_if ();
  sram_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mem_if ();

  sram_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk  (clk),
    .rst  (rst),
    .inst (inst_if),
    .data (data_if),
    .mem  (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tfail(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timeout got no event expected event at %0t", nm, $time);
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_valid = 0;
  bit          m_busy, m_acc, m_iok, m_dok;
  arb_owner_e  m_own, m_last;
  logic        m_wr;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_irdata, m_drdata;
  bit          grants[$];
  int          b2b_cnt = 0;
  int          handoff_cnt = 0;

  function automatic arb_owner_e model_winner(input logic ir, input logic dr, input arb_owner_e last);
    bit prefer_data;
`ifdef ARB_ROUND_ROBIN_EN
    prefer_data = (last == OWN_INST);
`else
    prefer_data = 1'b1;
`endif
    if (dr && (!ir || prefer_data)) return OWN_DATA;
    return OWN_INST;
  endfunction

  always @(negedge clk) begin
    if (m_valid) begin
      arb_owner_e w;
      bit exp_iaok, exp_daok, exp_mreq;
      w        = model_winner(inst_if.req, data_if.req, m_last);
      exp_iaok = !rst && !m_busy && inst_if.req && (w == OWN_INST);
      exp_daok = !rst && !m_busy && data_if.req && (w == OWN_DATA);
      exp_mreq = m_busy && !m_acc;
      chk("inst_addr_ok", 32'(inst_if.addr_ok), 32'(exp_iaok));
      chk("data_addr_ok", 32'(data_if.addr_ok), 32'(exp_daok));
      chk("mem_req",      32'(mem_if.req),      32'(exp_mreq));
      chk("inst_data_ok", 32'(inst_if.data_ok), 32'(m_iok));
      chk("data_data_ok", 32'(data_if.data_ok), 32'(m_dok));
      chk("inst_rdata",   inst_if.rdata,        m_irdata);
      chk("data_rdata",   data_if.rdata,        m_drdata);
      if (exp_mreq) begin
        chk("mem_wr",    32'(mem_if.wr),    32'(m_wr));
        chk("mem_wstrb", 32'(mem_if.wstrb), 32'(m_wstrb));
        chk("mem_addr",  mem_if.addr,       m_addr);
        chk("mem_wdata", mem_if.wdata,      m_wdata);
      end
      if (!rst) begin
        if (inst_if.addr_ok === 1'b1) grants.push_back(1'b0);
        if (data_if.addr_ok === 1'b1) grants.push_back(1'b1);
        if (inst_if.data_ok === 1'b1 && inst_if.addr_ok === 1'b1) b2b_cnt++;
        if (data_if.data_ok === 1'b1 && inst_if.addr_ok === 1'b1) handoff_cnt++;
      end
    end
    // advance the model to the state after the coming rising edge
    if (rst) begin
      m_busy = 0; m_acc = 0; m_iok = 0; m_dok = 0;
      m_own = OWN_INST; m_last = OWN_INST;
      m_wr = 0; m_wstrb = '0; m_addr = '0; m_wdata = '0;
      m_irdata = '0; m_drdata = '0;
      m_valid = 1;
    end else if (m_valid) begin
      bit was_busy;
      was_busy = m_busy;
      m_iok = 0;
      m_dok = 0;
      if (m_busy && m_acc && mem_if.data_ok) begin
        m_busy = 0;
        if (m_own == OWN_INST) begin
          m_irdata = mem_if.rdata;
          m_iok = 1;
        end else begin
          m_dok = 1;
          if (!m_wr) m_drdata = mem_if.rdata;
        end
      end else if (m_busy && !m_acc && mem_if.addr_ok) begin
        m_acc = 1;
      end
      if (!was_busy && (inst_if.req || data_if.req)) begin
        m_own  = model_winner(inst_if.req, data_if.req, m_last);
        m_last = m_own;
        m_busy = 1;
        m_acc  = 0;
        if (m_own == OWN_DATA) begin
          m_wr = data_if.wr; m_wstrb = data_if.wstrb;
          m_addr = data_if.addr; m_wdata = data_if.wdata;
        end else begin
          m_wr = 0; m_wstrb = '0; m_addr = inst_if.addr; m_wdata = '0;
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic        seen_wr;
  logic [3:0]  seen_wstrb;
  logic [31:0] seen_addr, seen_wdata;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic req_inst(input logic [31:0] a);
    bit ok = 0;
    inst_if.req  = 1'b1;
    inst_if.addr = a;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (inst_if.addr_ok === 1'b1) begin ok = 1; break; end
      cyc();
    end
    if (!ok) tfail("inst_accept");
    cyc();
    inst_if.req  = 1'b0;
    inst_if.addr = $urandom;
  endtask

  task automatic req_data(input logic wr, input logic [3:0] strb, input logic [31:0] a,
                          input logic [31:0] wd);
    bit ok = 0;
    data_if.req   = 1'b1;
    data_if.wr    = wr;
    data_if.wstrb = strb;
    data_if.addr  = a;
    data_if.wdata = wd;
    for (int n = 0; n < 200; n++) begin
      #1;
      if (data_if.addr_ok === 1'b1) begin ok = 1; break; end
      cyc();
    end
    if (!ok) tfail("data_accept");
    cyc();
    data_if.req   = 1'b0;
    data_if.wr    = ~wr;
    data_if.wstrb = ~strb;
    data_if.addr  = $urandom;
    data_if.wdata = $urandom;
  endtask

  task automatic serve(input int stall, input int lat, input logic [31:0] rd);
    bit ok = 0;
    for (int n = 0; n < 200; n++) begin
      if (mem_if.req === 1'b1) begin ok = 1; break; end
      cyc();
    end
    if (!ok) begin
      tfail("serve_mem_req");
      return;
    end
    seen_wr    = mem_if.wr;
    seen_wstrb = mem_if.wstrb;
    seen_addr  = mem_if.addr;
    seen_wdata = mem_if.wdata;
    repeat (stall) cyc();
    mem_if.addr_ok = 1'b1;
    cyc();
    mem_if.addr_ok = 1'b0;
    repeat (lat) cyc();
    mem_if.data_ok = 1'b1;
    mem_if.rdata   = rd;
    cyc();
    mem_if.data_ok = 1'b0;
    mem_if.rdata   = $urandom;
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed tests ----------------
  initial begin
    bit exp_order[$];
    rst = 1'b1;
    inst_if.req = 0; inst_if.wr = 0; inst_if.wstrb = '0; inst_if.addr = '0; inst_if.wdata = '0;
    data_if.req = 0; data_if.wr = 0; data_if.wstrb = '0; data_if.addr = '0; data_if.wdata = '0;
    mem_if.addr_ok = 0; mem_if.data_ok = 0; mem_if.rdata = '0;
    repeat (2) cyc();
    rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_mem_req",   32'(mem_if.req),   32'h0);
    chk("rst_mem_addr",  mem_if.addr,       32'h0);
    chk("rst_mem_wstrb", 32'(mem_if.wstrb), 32'h0);
    chk("rst_inst_rd",   inst_if.rdata,     32'h0);
    chk("rst_data_ok",   32'(data_if.data_ok), 32'h0);
    sync();

    // single fetch
    grants.delete();
    fork
      req_inst(32'hBFC0_0000);
      serve(2, 1, 32'h3C1D_0000);
    join
    @(negedge clk);
    chk("fetch_mem_addr", seen_addr, 32'hBFC0_0000);
    chk("fetch_mem_wr",   32'(seen_wr), 32'h0);
    chk("fetch_data_ok",  32'(inst_if.data_ok), 32'h1);
    chk("fetch_rdata",    inst_if.rdata, 32'h3C1D_0000);
    chk("fetch_grants",   32'(grants.size()), 32'd1);
    sync();

    // load then store; the store must leave data_rdata alone
    fork
      req_data(1'b0, 4'h0, 32'h0000_1000, 32'h0);
      serve(0, 1, 32'hCAFE_F00D);
    join
    fork
      req_data(1'b1, 4'b0011, 32'h8000_0010, 32'h1234_ABCD);
      serve(3, 2, 32'h5555_AAAA);
    join
    @(negedge clk);
    chk("store_mem_wr",    32'(seen_wr),    32'h1);
    chk("store_mem_wstrb", 32'(seen_wstrb), 32'h3);
    chk("store_mem_addr",  seen_addr,       32'h8000_0010);
    chk("store_mem_wdata", seen_wdata,      32'h1234_ABCD);
    chk("store_data_ok",   32'(data_if.data_ok), 32'h1);
    chk("store_rdata_kept", data_if.rdata,  32'hCAFE_F00D);
    sync();

    // back-to-back fetches with inst_req held across the first completion
    b2b_cnt = 0;
    fork
      begin
        req_inst(32'h0000_0100);
        req_inst(32'h0000_0104);
      end
      begin
        serve(0, 0, 32'h1111_1111);
        serve(1, 0, 32'h2222_2222);
      end
    join
    @(negedge clk);
    chk("b2b_same_cycle", 32'(b2b_cnt), 32'd1);
    chk("b2b_rdata",      inst_if.rdata, 32'h2222_2222);
    sync();

    // reset while in DATA: the late mem_data_ok must be ignored
    fork
      req_inst(32'h0000_0200);
      begin
        for (int n = 0; n < 50 && mem_if.req !== 1'b1; n++) cyc();
        mem_if.addr_ok = 1'b1;
        cyc();
        mem_if.addr_ok = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        mem_if.data_ok = 1'b1;
        mem_if.rdata   = 32'hDEAD_BEEF;
        cyc();
        mem_if.data_ok = 1'b0;
      end
    join
    @(negedge clk);
    chk("rstdata_inst_ok",  32'(inst_if.data_ok), 32'h0);
    chk("rstdata_mem_req",  32'(mem_if.req),      32'h0);
    chk("rstdata_inst_rd",  inst_if.rdata,        32'h0);
    chk("rstdata_data_rd",  data_if.rdata,        32'h0);
    sync();

    // ties right after reset: both requesters each issue two loads/fetches
    grants.delete();
    handoff_cnt = 0;
    fork
      begin
        req_data(1'b0, 4'h0, 32'h0000_2000, 32'h0);
        req_data(1'b0, 4'h0, 32'h0000_2004, 32'h0);
      end
      begin
        req_inst(32'h0000_3000);
        req_inst(32'h0000_3004);
      end
      begin
        serve(1, 1, 32'hA000_0001);
        serve(1, 1, 32'hA000_0002);
        serve(1, 1, 32'hA000_0003);
        serve(1, 1, 32'hA000_0004);
      end
    join
`ifdef ARB_ROUND_ROBIN_EN
    exp_order = '{1'b1, 1'b0, 1'b1, 1'b0};
    chk("tie_handoffs", 32'(handoff_cnt), 32'd2);
`else
    exp_order = '{1'b1, 1'b1, 1'b0, 1'b0};
    chk("tie_handoffs", 32'(handoff_cnt), 32'd1);
`endif
    chk("tie_grant_count", 32'(grants.size()), 32'd4);
    for (int i = 0; i < 4 && i < grants.size(); i++) begin
      chk($sformatf("tie_grant_%0d", i), 32'(grants[i]), 32'(exp_order[i]));
    end
    @(negedge clk);
    chk("tie_last_inst_rd", inst_if.rdata, 32'hA000_0004);
`ifdef ARB_ROUND_ROBIN_EN
    chk("tie_last_data_rd", data_if.rdata, 32'hA000_0003);
`else
    chk("tie_last_data_rd", data_if.rdata, 32'hA000_0002);
`endif
    repeat (3) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hang expected finish");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Shares one sram-like memory port between the CPU instruction-fetch requester and the data (load/store) requester.
- Sits between the CPU core's inst/data sram-like interfaces and the single downstream memory bridge.
- One transaction in flight at a time.
- Three-state FSM; request fields are latched so upstream may change its inputs after address acceptance.

Parameters:
- ADDR_W, 32, address width of all ports
- DATA_W, 32, data width; DATA_W/8 is the write-strobe width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- inst_req  in  1  fetch request, held until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  one-cycle pulse: fetch request accepted
- inst_data_ok  out  1  one-cycle pulse: inst_rdata valid
- inst_rdata  out  DATA_W  fetched word
- data_req  in  1  load/store request, held until data_addr_ok
- data_wr  in  1  1 = store, 0 = load
- data_wstrb  in  DATA_W/8  byte write enables (stores only)
- data_addr  in  ADDR_W  load/store address
- data_wdata  in  DATA_W  store data
- data_addr_ok  out  1  one-cycle pulse: data request accepted
- data_data_ok  out  1  one-cycle pulse: load data valid, or store done
- data_rdata  out  DATA_W  load data
- mem_req  out  1  downstream request
- mem_wr  out  1  downstream write flag
- mem_wstrb  out  DATA_W/8  downstream byte enables
- mem_addr  out  ADDR_W  downstream address
- mem_wdata  out  DATA_W  downstream write data
- mem_addr_ok  in  1  downstream accepted the request
- mem_data_ok  in  1  downstream response valid
- mem_rdata  in  DATA_W  downstream read data

Behaviour:
- Reset (rst=1 at the clk edge):
  - FSM goes to IDLE.
  - All outputs go to 0.
  - Latched fields and grant owner are cleared.
  - Any in-flight transaction is abandoned; a later mem_data_ok is ignored until a new grant reaches DATA.
- IDLE:
  - If any req is high, pick a winner (fixed priority: data over inst).
  - Pulse the winner's *_addr_ok combinationally in this same cycle.
  - Latch wr/wstrb/addr/wdata and the owner id; go to ADDR.
  - An inst grant latches wr=0, wstrb=0.
- ADDR:
  - mem_req=1; mem_* are driven from the latches and held stable.
  - Stay until mem_addr_ok=1, then go to DATA.
  - mem_data_ok is ignored in ADDR; the slave never asserts it in the same cycle as addr_ok.
- DATA:
  - mem_req=0.
  - On mem_data_ok=1: register mem_rdata into the owner's *_rdata, pulse the owner's *_data_ok on the next cycle, and go to IDLE.
  - For stores, data_rdata is unchanged.
- Latency:
  - req seen in cycle N → addr_ok in cycle N, mem_req from N+1.
  - mem_data_ok in cycle M → *_data_ok in cycle M+1.
  - The next grant can occur in cycle M+1 (back-to-back).
- Non-owner *_rdata holds its last value; the non-owner *_data_ok stays 0.
- Simultaneous requests: the loser keeps its req high and is granted in the next IDLE cycle; no request is dropped.
- A req deasserted before addr_ok is never forwarded.
- mem_req is never high outside ADDR; at most one *_addr_ok pulses per cycle.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_owner register, reset to INST.
  - On a tie, the requester that is not last_owner wins, so the first tie after reset goes to data.
  - last_owner updates on each grant.
- Undefined: fixed data-over-inst priority; no last_owner register.

Decomposition:
- Shared package sram_arb_pkg holds:
  - state encoding: IDLE=2'd0, ADDR=2'd1, DATA=2'd2
  - owner ids: OWN_INST=1'b0, OWN_DATA=1'b1
- One natural sub-module, sram_arb_pick: combinational winner select from inst_req, data_req and last_owner, including the RR logic.
- The FSM and latches stay in the top.

Test Plan:
- Reset mid-DATA: rst while in DATA, then mem_data_ok=1 → no *_data_ok; FSM in IDLE; all outputs 0.
- Single fetch: inst_req, addr 0xBFC00000; mem_addr_ok after 2 cycles; mem_data_ok with 0x3C1D0000 → inst_addr_ok in the request cycle, mem_addr=0xBFC00000, mem_wr=0, inst_data_ok one cycle later with inst_rdata=0x3C1D0000.
- Store: data_req, wr=1, wstrb=4'b0011, addr 0x8000_0010, wdata 0x1234_ABCD → mem_* carry exactly these values and stay stable during a 3-cycle addr_ok stall; data_data_ok pulses; data_rdata is unchanged.
- Tie, fixed priority: inst_req and data_req both high → data granted first, then inst granted in the IDLE cycle right after data_data_ok; inst_req held throughout.
- Tie with ARB_ROUND_ROBIN_EN: three consecutive ties → grant order data, inst, data.
- Back-to-back: mem_data_ok in cycle M with inst_req held → inst_data_ok and the next inst_addr_ok both pulse in cycle M+1.
